demux: RTL and testbench
========================

DEMUX -- requirements
Module: demux

Interface
REQ-001 Parameter D_WIDTH, default 8, width of every data port.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 select  input  2  destination for the word accepted this cycle: 0, 1, 2 = channel 0/1/2; 3 = discard.
REQ-005 data_i  input  D_WIDTH  upstream data word.
REQ-006 valid_i  input  1  upstream word present.
REQ-007 ready_o  output  1  block accepts the upstream word this cycle.
REQ-008 dataK_o  output  D_WIDTH  channel K head word, for K = 0, 1, 2.
REQ-009 validK_o  output  1  channel K head word present, for K = 0, 1, 2.
REQ-010 readyK_i  input  1  channel K consumer accepts the head word, for K = 0, 1, 2.
REQ-011 drop_cnt_o  output  8  count of words accepted while select = 3.

Function
REQ-012 Each channel K SHALL contain an independent 2-entry FIFO, with first-word fall-through at the output.
REQ-013 validK_o SHALL equal 1 exactly when FIFO K is non-empty.
REQ-014 dataK_o SHALL equal the oldest entry of FIFO K when FIFO K is non-empty, and 0 when it is empty.
REQ-015 ready_o SHALL be combinational:
- 0 while rst = 1;
- otherwise 1 when select = 3;
- otherwise 1 when FIFO[select] holds fewer than 2 entries.
REQ-016 Accept SHALL occur on a rising edge where valid_i = 1 and ready_o = 1. select and data_i SHALL be sampled only on that edge.
REQ-017 On accept with select = 0 to 2, data_i SHALL be written to FIFO[select], and no other FIFO SHALL change.
REQ-018 On accept with select = 3, the word SHALL be discarded, and drop_cnt_o SHALL increment by 1, saturating at 255 (no wrap-around).
REQ-019 Pop of channel K SHALL occur on a rising edge where validK_o = 1 and readyK_i = 1; the head entry is removed.
REQ-020 Latency SHALL be 1 cycle: a word accepted at edge N appears on validK_o/dataK_o after edge N if FIFO K was empty. There is no same-cycle pass-through.
REQ-021 Per-channel order SHALL be preserved: words leave channel K in the order they were accepted for channel K.
REQ-022 Push and pop on the same channel at the same edge SHALL both take effect:
- occupancy is unchanged;
- the pushed word queues behind the remaining entry;
- this is legal only when occupancy < 2 before the edge.
REQ-023 When FIFO K is full, a same-edge pop SHALL NOT raise ready_o in that cycle; the push is refused and upstream holds the word.
REQ-024 Pops on the three channels SHALL be independent and may occur at the same edge as each other and as a push.
REQ-025 readyK_i asserted while validK_o = 0 SHALL have no effect.
REQ-026 valid_i = 0 SHALL cause no FIFO or counter change, whatever the value of select.
REQ-027 A change of select between edges SHALL have no effect other than re-evaluating ready_o.

Reset
REQ-028 While rst = 1 at a rising edge, all FIFOs SHALL become empty and all FIFO storage SHALL be cleared to 0.
REQ-029 While rst = 1 at a rising edge, validK_o SHALL be 0, dataK_o SHALL be 0 and drop_cnt_o SHALL be 0.
REQ-030 During a rst = 1 edge, the upstream word and all channel pops SHALL be ignored, including a reset mid-stream with words still in the FIFOs (those words are lost).
REQ-031 On the first edge after rst returns to 0, the block SHALL operate normally, with ready_o = 1 for any select.

Verification
REQ-032 Basic route: after reset, select=1, data_i=8'hA5, valid_i=1 for one edge, ready1_i=0 -> valid1_o=1 and data1_o=8'hA5 on the next cycle; valid0_o=0 and valid2_o=0.
REQ-033 Full/backpressure: select=2, push 8'h11 then 8'h22 with ready2_i=0 -> ready_o=0 on the third cycle. Then set ready2_i=1 -> data2_o shows 8'h11 then 8'h22, and ready_o returns to 1 after the first pop.
REQ-034 Simultaneous events: channel 0 holds 1 entry (8'h01); at one edge push 8'h02 to channel 0, pop channel 0, and pop channel 1 (holding 8'h10) -> channel 0 occupancy stays 1 with head 8'h02, and channel 1 becomes empty.
REQ-035 Discard/saturation: 260 accepts with select=3 -> ready_o=1 throughout, no validK_o asserted, drop_cnt_o=255 at the end.
REQ-036 Reset mid-operation: 2 words in channel 0 and drop_cnt_o=5; assert rst for one edge while valid_i=1 and ready0_i=1 -> all validK_o=0, all dataK_o=0, drop_cnt_o=0, and ready_o=0 during rst.

Source files
------------

// File: rtl/demux.sv
// ---------------------------------------------------------------------------
// demux
//   Routes an upstream valid/ready word stream to one of three output
//   channels, or discards it. Each channel owns a 2-entry first-word
//   fall-through FIFO, so a routed word shows up on its channel one cycle
//   after it is accepted. Discarded words are counted with a saturating
//   8-bit counter.
//
// Ports
//   clk                 rising-edge clock
//   rst                 synchronous active-high reset
//   select   [1:0]      0..2 = destination channel, 3 = discard
//   data_i   [W-1:0]    upstream word
//   valid_i             upstream word present
//   ready_o             upstream word is accepted this cycle (combinational)
//   dataK_o  [W-1:0]    channel K head word (0 when empty), K = 0..2
//   validK_o            channel K non-empty
//   readyK_i            channel K consumer takes the head word
//   drop_cnt_o [7:0]    number of discarded words, saturating at 255
// ---------------------------------------------------------------------------
module demux #(
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         select,
  input  logic [D_WIDTH-1:0] data_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [D_WIDTH-1:0] data0_o,
  output logic               valid0_o,
  input  logic               ready0_i,
  output logic [D_WIDTH-1:0] data1_o,
  output logic               valid1_o,
  input  logic               ready1_i,
  output logic [D_WIDTH-1:0] data2_o,
  output logic               valid2_o,
  input  logic               ready2_i,
  output logic [7:0]         drop_cnt_o
);

  localparam int NUM_CH = 3;

  // Bit 3 stands for the discard destination, which is never full, so
  // ready_o can be looked up directly with select.
  logic [3:0]         w_full;
  logic               w_accept;
  logic [NUM_CH-1:0]  w_pop_req;
  logic [NUM_CH-1:0]  w_valid;
  logic [D_WIDTH-1:0] w_data [NUM_CH];
  logic [7:0]         r_drop_cnt;

  assign w_full[3]  = 1'b0;
  assign w_pop_req  = {ready2_i, ready1_i, ready0_i};

  // A pop in the same cycle does not free a slot for the upstream word:
  // ready_o looks only at the current occupancy.
  assign ready_o  = !rst && !w_full[select];
  assign w_accept = valid_i && ready_o;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [1:0]         r_cnt;
      logic [D_WIDTH-1:0] r_mem [2];   // slot 0 is always the head
      logic               w_push;
      logic               w_pop;

      assign w_push = w_accept && (select == 2'(gi));
      assign w_pop  = (r_cnt != 2'd0) && w_pop_req[gi];

      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt     <= 2'd0;
          r_mem[0]  <= '0;
          r_mem[1]  <= '0;
        end else begin
          case ({w_push, w_pop})
            2'b11: begin
              // Only reachable with one entry: the head leaves and the new
              // word becomes the head, occupancy stays at one.
              r_mem[0] <= data_i;
            end
            2'b01: begin
              r_mem[0] <= r_mem[1];
              r_mem[1] <= '0;
              r_cnt    <= r_cnt - 2'd1;
            end
            2'b10: begin
              if (r_cnt == 2'd0) begin
                r_mem[0] <= data_i;
              end else begin
                r_mem[1] <= data_i;
              end
              r_cnt <= r_cnt + 2'd1;
            end
            default: ;
          endcase
        end
      end

      assign w_full[gi]  = (r_cnt == 2'd2);
      assign w_valid[gi] = (r_cnt != 2'd0);
      assign w_data[gi]  = w_valid[gi] ? r_mem[0] : '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= 8'd0;
    end else if (w_accept && (select == 2'd3) && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign data0_o    = w_data[0];
  assign data1_o    = w_data[1];
  assign data2_o    = w_data[2];
  assign valid0_o   = w_valid[0];
  assign valid1_o   = w_valid[1];
  assign valid2_o   = w_valid[2];
  assign drop_cnt_o = r_drop_cnt;

endmodule

// File: tb/tb_demux.sv
module tb_demux;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   select;
  logic [W-1:0] data_i;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] data0_o, data1_o, data2_o;
  logic         valid0_o, valid1_o, valid2_o;
  logic         rdy [3];
  logic [7:0]   drop_cnt_o;

  logic [W-1:0] dout [3];
  logic         vout [3];

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per channel plus a drop count.
  logic [W-1:0] mq [3][$];
  int           m_drop;

  always #5 clk = ~clk;

  demux #(.D_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .select(select), .data_i(data_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .data0_o(data0_o), .valid0_o(valid0_o), .ready0_i(rdy[0]),
    .data1_o(data1_o), .valid1_o(valid1_o), .ready1_i(rdy[1]),
    .data2_o(data2_o), .valid2_o(valid2_o), .ready2_i(rdy[2]),
    .drop_cnt_o(drop_cnt_o)
  );

  assign dout[0] = data0_o;
  assign dout[1] = data1_o;
  assign dout[2] = data2_o;
  assign vout[0] = valid0_o;
  assign vout[1] = valid1_o;
  assign vout[2] = valid2_o;

  function automatic logic model_ready();
    if (rst) return 1'b0;
    if (select == 2'd3) return 1'b1;
    return (mq[select].size() < 2);
  endfunction

  // Apply the current inputs to the model as one clock edge.
  task automatic model_edge();
    logic acc;
    if (rst) begin
      for (int k = 0; k < 3; k++) mq[k].delete();
      m_drop = 0;
    end else begin
      acc = valid_i && model_ready();
      for (int k = 0; k < 3; k++)
        if (rdy[k] && mq[k].size() > 0) void'(mq[k].pop_front());
      if (acc) begin
        if (select == 2'd3) begin
          if (m_drop < 255) m_drop++;
        end else begin
          mq[select].push_back(data_i);
        end
      end
    end
  endtask

  // Advance one clock edge; returns 1 ns after the edge.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i = 1'b0; select = 2'd0; data_i = '0;
    for (int k = 0; k < 3; k++) rdy[k] = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (vout[k] !== 1'b0 || dout[k] !== '0) begin
        errors++;
        $display("FAIL reset_ch%0d valid=%b data=%h expected valid=0 data=00", k, vout[k], dout[k]);
      end
    end
    checks++;
    if (drop_cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL reset_drop got %0d expected 0", drop_cnt_o);
    end
    for (int s = 0; s < 4; s++) begin
      select = 2'(s); valid_i = 1'b1; #1;
      checks++;
      if (ready_o !== 1'b1) begin
        errors++;
        $display("FAIL reset_ready_sel%0d got %b expected 1", s, ready_o);
      end
    end
    idle_inputs(); #1;
  endtask

  task automatic test_basic_route();
    do_reset();
    select = 2'd1; data_i = 8'hA5; valid_i = 1'b1; #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++; $display("FAIL route_ready got %b expected 1", ready_o);
    end
    step();
    idle_inputs(); #1;
    checks++;
    if (valid1_o !== 1'b1 || data1_o !== 8'hA5) begin
      errors++; $display("FAIL route_ch1 valid=%b data=%h expected valid=1 data=a5", valid1_o, data1_o);
    end
    checks++;
    if (valid0_o !== 1'b0 || valid2_o !== 1'b0) begin
      errors++; $display("FAIL route_others valid0=%b valid2=%b expected 0 0", valid0_o, valid2_o);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    select = 2'd2; valid_i = 1'b1; data_i = 8'h11; #1; step();
    data_i = 8'h22; #1; step();
    data_i = 8'h33; #1;
    checks++;
    if (ready_o !== 1'b0) begin
      errors++; $display("FAIL bp_full_ready got %b expected 0", ready_o);
    end
    // Pop while full must not open ready_o in the same cycle.
    rdy[2] = 1'b1; valid_i = 1'b0; #1;
    checks++;
    if (ready_o !== 1'b0 || data2_o !== 8'h11) begin
      errors++; $display("FAIL bp_pop_full ready=%b data2=%h expected ready=0 data2=11", ready_o, data2_o);
    end
    step();
    checks++;
    if (ready_o !== 1'b1 || data2_o !== 8'h22 || valid2_o !== 1'b1) begin
      errors++; $display("FAIL bp_second ready=%b valid2=%b data2=%h expected 1 1 22", ready_o, valid2_o, data2_o);
    end
    step();
    checks++;
    if (valid2_o !== 1'b0 || data2_o !== 8'h00) begin
      errors++; $display("FAIL bp_drained valid2=%b data2=%h expected 0 00", valid2_o, data2_o);
    end
    idle_inputs(); #1;
  endtask

  task automatic test_simultaneous();
    do_reset();
    select = 2'd0; data_i = 8'h01; valid_i = 1'b1; #1; step();
    select = 2'd1; data_i = 8'h10; #1; step();
    select = 2'd0; data_i = 8'h02; rdy[0] = 1'b1; rdy[1] = 1'b1; #1; step();
    idle_inputs(); #1;
    checks++;
    if (valid0_o !== 1'b1 || data0_o !== 8'h02) begin
      errors++; $display("FAIL simul_ch0 valid=%b data=%h expected 1 02", valid0_o, data0_o);
    end
    checks++;
    if (valid1_o !== 1'b0) begin
      errors++; $display("FAIL simul_ch1 valid=%b expected 0", valid1_o);
    end
    rdy[0] = 1'b1; #1; step();
    checks++;
    if (valid0_o !== 1'b0) begin
      errors++; $display("FAIL simul_ch0_occ1 valid=%b expected 0 after one pop", valid0_o);
    end
    idle_inputs(); #1;
  endtask

  task automatic test_discard_saturation();
    do_reset();
    select = 2'd3; valid_i = 1'b1;
    for (int i = 0; i < 260; i++) begin
      data_i = 8'($urandom); #1;
      checks++;
      if (ready_o !== 1'b1 || valid0_o || valid1_o || valid2_o) begin
        errors++;
        $display("FAIL discard_cycle%0d ready=%b valids=%b%b%b expected ready=1 valids=000", i, ready_o, valid0_o, valid1_o, valid2_o);
      end
      step();
    end
    idle_inputs(); #1;
    checks++;
    if (drop_cnt_o !== 8'd255) begin
      errors++; $display("FAIL discard_sat got %0d expected 255", drop_cnt_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    select = 2'd0; valid_i = 1'b1; data_i = 8'h5A; #1; step();
    data_i = 8'h6B; #1; step();
    select = 2'd3;
    for (int i = 0; i < 5; i++) step();
    idle_inputs(); #1;
    checks++;
    if (drop_cnt_o !== 8'd5 || valid0_o !== 1'b1) begin
      errors++; $display("FAIL mid_setup drop=%0d valid0=%b expected 5 1", drop_cnt_o, valid0_o);
    end
    rst = 1'b1; valid_i = 1'b1; select = 2'd1; data_i = 8'hEE; rdy[0] = 1'b1; #1;
    checks++;
    if (ready_o !== 1'b0) begin
      errors++; $display("FAIL mid_ready_in_rst got %b expected 0", ready_o);
    end
    step();
    rst = 1'b0; idle_inputs(); #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (vout[k] !== 1'b0 || dout[k] !== '0) begin
        errors++; $display("FAIL mid_ch%0d valid=%b data=%h expected 0 00", k, vout[k], dout[k]);
      end
    end
    checks++;
    if (drop_cnt_o !== 8'd0) begin
      errors++; $display("FAIL mid_drop got %0d expected 0", drop_cnt_o);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] exp_d;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(99) == 0);
      valid_i = ($urandom_range(3) != 0);
      select  = 2'($urandom_range(3));
      data_i  = 8'($urandom);
      for (int k = 0; k < 3; k++) rdy[k] = ($urandom_range(2) != 0);
      #1;
      checks++;
      if (ready_o !== model_ready()) begin
        errors++; $display("FAIL rand_ready cyc=%0d got %b expected %b", c, ready_o, model_ready());
      end
      for (int k = 0; k < 3; k++) begin
        exp_d = (mq[k].size() > 0) ? mq[k][0] : '0;
        checks++;
        if (vout[k] !== (mq[k].size() > 0) || dout[k] !== exp_d) begin
          errors++;
          $display("FAIL rand_ch%0d cyc=%0d valid=%b data=%h expected valid=%b data=%h", k, c, vout[k], dout[k], mq[k].size() > 0, exp_d);
        end
      end
      checks++;
      if (drop_cnt_o !== 8'(m_drop)) begin
        errors++; $display("FAIL rand_drop cyc=%0d got %0d expected %0d", c, drop_cnt_o, m_drop);
      end
      step();
    end
    rst = 1'b0; idle_inputs(); #1;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    m_drop = 0;
    @(posedge clk); #1;
    test_reset();
    $display("test_reset done checks=%0d errors=%0d", checks, errors);
    test_basic_route();
    $display("test_basic_route done checks=%0d errors=%0d", checks, errors);
    test_backpressure();
    $display("test_backpressure done checks=%0d errors=%0d", checks, errors);
    test_simultaneous();
    $display("test_simultaneous done checks=%0d errors=%0d", checks, errors);
    test_discard_saturation();
    $display("test_discard_saturation done checks=%0d errors=%0d", checks, errors);
    test_reset_mid();
    $display("test_reset_mid done checks=%0d errors=%0d", checks, errors);
    test_random();
    $display("test_random done checks=%0d errors=%0d", checks, errors);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
